// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

    localparam int AW_DEFAULT = 32;
    localparam int DW_DEFAULT = 32;
    localparam int CNT_W      = 32;

    // Size/sign code driven on the memory port for instruction fetches (full word).
    localparam logic [2:0] FETCH_FUNCT3 = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_F = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } grant_t;

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                 input logic             en);
        if (en && (value != {CNT_W{1'b1}})) begin
            return value + 1'b1;
        end
        return value;
    endfunction

endpackage

// File: rtl/mem_arb_perf_cnt.sv
// Three saturating event counters for the memory port arbiter.
module mem_arb_perf_cnt
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_fetch,
    input  logic             inc_data,
    input  logic             inc_conflict,
    output logic [CNT_W-1:0] perf_fetch,
    output logic [CNT_W-1:0] perf_data,
    output logic [CNT_W-1:0] perf_conflict
);

    // Count completed fetches, completed data accesses and waiting-requester cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetch    <= '0;
            perf_data     <= '0;
            perf_conflict <= '0;
        end else begin
            perf_fetch    <= sat_inc(perf_fetch, inc_fetch);
            perf_data     <= sat_inc(perf_data, inc_data);
            perf_conflict <= sat_inc(perf_conflict, inc_conflict);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Request/grant/response sequencer sharing one single-ported memory between
// instruction fetch and load/store. Round-robin on conflicts, one access at a
// time, one-cycle response pulse per completed access.
// Optional build macro: MEM_PORT_ARB_PERF_EN enables the performance counters;
// without it the perf_* ports read zero.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    // fetch side
    input  logic             if_req,
    input  logic [AW-1:0]    if_addr,
    output logic             if_rvalid,
    output logic [DW-1:0]    if_rdata,
    output logic             if_stall,
    // data side
    input  logic             d_req,
    input  logic             d_we,
    input  logic [AW-1:0]    d_addr,
    input  logic [DW-1:0]    d_wdata,
    input  logic [2:0]       d_funct3,
    output logic             d_rvalid,
    output logic [DW-1:0]    d_rdata,
    output logic             d_stall,
    // memory side
    output logic             mem_req,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata,
    output logic [2:0]       mem_funct3,
    input  logic             mem_ready,
    input  logic [DW-1:0]    mem_rdata,
    // performance counters
    output logic [CNT_W-1:0] perf_fetch,
    output logic [CNT_W-1:0] perf_data,
    output logic [CNT_W-1:0] perf_conflict
);

    arb_state_t state;
    arb_state_t next_state;
    grant_t     last_grant;
    logic       grant_f;
    logic       grant_d;
    logic       capture;

    // State register and round-robin history; last_grant records who was last served.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= FETCH;
        end else begin
            state <= next_state;
            if (capture) begin
                last_grant <= (state == BUSY_D) ? DATA : FETCH;
            end
        end
    end

    // Next-state, arbitration and handshake outputs.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        grant_f    = 1'b0;
        grant_d    = 1'b0;
        capture    = 1'b0;
        mem_req    = 1'b0;
        if_rvalid  = 1'b0;
        d_rvalid   = 1'b0;
        case (state)
            IDLE: begin
                if (if_req && d_req) begin
                    // Data wins a conflict unless it was the one served last.
                    if (last_grant == DATA) begin
                        grant_f = 1'b1;
                    end else begin
                        grant_d = 1'b1;
                    end
                end else if (if_req) begin
                    grant_f = 1'b1;
                end else if (d_req) begin
                    grant_d = 1'b1;
                end
                if (grant_f) begin
                    next_state = BUSY_F;
                end else if (grant_d) begin
                    next_state = BUSY_D;
                end
            end
            BUSY_F, BUSY_D: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    capture    = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                // No arbitration here: the finishing requester still shows its old req.
                if_rvalid  = (last_grant == FETCH);
                d_rvalid   = (last_grant == DATA);
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Memory-side request registers, loaded once at grant and held through the access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_funct3 <= '0;
        end else if (grant_d) begin
            mem_we     <= d_we;
            mem_addr   <= d_addr;
            mem_wdata  <= d_wdata;
            mem_funct3 <= d_funct3;
        end else if (grant_f) begin
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            mem_funct3 <= FETCH_FUNCT3;
        end
    end

    // Response registers; a store completion leaves d_rdata untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_rdata <= '0;
            d_rdata  <= '0;
        end else if (capture) begin
            if (state == BUSY_F) begin
                if_rdata <= mem_rdata;
            end else if (!mem_we) begin
                d_rdata <= mem_rdata;
            end
        end
    end

    assign if_stall = if_req & ~if_rvalid;
    assign d_stall  = d_req & ~d_rvalid;

`ifdef MEM_PORT_ARB_PERF_EN
    logic conflict;

    // A requester is waiting: both asking in IDLE, or the other side is being served.
    assign conflict = ((state == IDLE)   && if_req && d_req) ||
                      ((state == BUSY_D) && if_req) ||
                      ((state == BUSY_F) && d_req);

    mem_arb_perf_cnt u_perf_cnt (
        .clk          (clk),
        .reset        (reset),
        .inc_fetch    (if_rvalid),
        .inc_data     (d_rvalid),
        .inc_conflict (conflict),
        .perf_fetch   (perf_fetch),
        .perf_data    (perf_data),
        .perf_conflict(perf_conflict)
    );
`else
    assign perf_fetch    = '0;
    assign perf_data     = '0;
    assign perf_conflict = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter. Expected counter values are
// the PERF-build values and collapse to zero when MEM_PORT_ARB_PERF_EN is undefined.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [2:0]  d_funct3;
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } in_t;

    typedef struct packed {
        logic        mem_req;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [2:0]  mem_funct3;
        logic        if_rvalid;
        logic [31:0] if_rdata;
        logic        if_stall;
        logic        d_rvalid;
        logic [31:0] d_rdata;
        logic        d_stall;
        logic [31:0] perf_fetch;
        logic [31:0] perf_data;
        logic [31:0] perf_conflict;
    } out_t;

    typedef struct {
        string name;
        in_t   stim;
        out_t  exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we, mem_ready;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [2:0]  d_funct3;
    logic        if_rvalid, if_stall, d_rvalid, d_stall, mem_req, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [2:0]  mem_funct3;
    logic [31:0] perf_fetch, perf_data, perf_conflict;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [31:0] I0 = 32'h0050_0093;
    localparam logic [31:0] I1 = 32'h0010_0073;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [31:0] W1 = 32'h1111_1111;
    localparam logic [31:0] LD = 32'hCAFE_F00D;
    localparam logic [31:0] LA = 32'h0000_AAAA;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_rvalid    (if_rvalid),
        .if_rdata     (if_rdata),
        .if_stall     (if_stall),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_funct3     (d_funct3),
        .d_rvalid     (d_rvalid),
        .d_rdata      (d_rdata),
        .d_stall      (d_stall),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_funct3   (mem_funct3),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .perf_fetch   (perf_fetch),
        .perf_data    (perf_data),
        .perf_conflict(perf_conflict)
    );

    function automatic logic [31:0] pv(input int v);
`ifdef MEM_PORT_ARB_PERF_EN
        return v;
`else
        return (v == v) ? 32'd0 : 32'd0;
`endif
    endfunction

    function automatic in_t mk_in(input logic ir, input logic [31:0] ia,
                                  input logic dr, input logic dw, input logic [31:0] da,
                                  input logic [31:0] dd, input logic [2:0] f3,
                                  input logic mr, input logic [31:0] md);
        in_t v;
        v = '{ir, ia, dr, dw, da, dd, f3, mr, md};
        return v;
    endfunction

    function automatic out_t mk_out(input logic mq, input logic mw, input logic [31:0] ma,
                                    input logic [31:0] mwd, input logic [2:0] mf3,
                                    input logic iv, input logic [31:0] id, input logic is,
                                    input logic dv, input logic [31:0] dd, input logic ds,
                                    input int pf, input int pd, input int pc);
        out_t v;
        v = '{mq, mw, ma, mwd, mf3, iv, id, is, dv, dd, ds, pv(pf), pv(pd), pv(pc)};
        return v;
    endfunction

    task automatic drive(input in_t s);
        if_req    = s.if_req;
        if_addr   = s.if_addr;
        d_req     = s.d_req;
        d_we      = s.d_we;
        d_addr    = s.d_addr;
        d_wdata   = s.d_wdata;
        d_funct3  = s.d_funct3;
        mem_ready = s.mem_ready;
        mem_rdata = s.mem_rdata;
    endtask

    task automatic check(input string name, input out_t exp);
        out_t got;
        got = '{mem_req, mem_we, mem_addr, mem_wdata, mem_funct3, if_rvalid, if_rdata,
                if_stall, d_rvalid, d_rdata, d_stall, perf_fetch, perf_data, perf_conflict};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got req=%b we=%b addr=%h wd=%h f3=%h ifv=%b ifd=%h ifs=%b dv=%b dd=%h ds=%b perf=%0d/%0d/%0d, want req=%b we=%b addr=%h wd=%h f3=%h ifv=%b ifd=%h ifs=%b dv=%b dd=%h ds=%b perf=%0d/%0d/%0d",
                     name, got.mem_req, got.mem_we, got.mem_addr, got.mem_wdata, got.mem_funct3,
                     got.if_rvalid, got.if_rdata, got.if_stall, got.d_rvalid, got.d_rdata, got.d_stall,
                     got.perf_fetch, got.perf_data, got.perf_conflict,
                     exp.mem_req, exp.mem_we, exp.mem_addr, exp.mem_wdata, exp.mem_funct3,
                     exp.if_rvalid, exp.if_rdata, exp.if_stall, exp.d_rvalid, exp.d_rdata, exp.d_stall,
                     exp.perf_fetch, exp.perf_data, exp.perf_conflict);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge, check, then move to the next falling edge.
    task automatic step(input string name, input in_t s, input out_t exp);
        drive(s);
        #1;
        check(name, exp);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        drive('0);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion before it");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[$];
        out_t zero_o;
        zero_o = mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Fetch only (1-cycle memory), store (3-cycle memory), then load held through RESP.
        vt.push_back('{"reset idle",   mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0),                  zero_o});
        vt.push_back('{"fetch req",    mk_in(1, 32'h40, 0, 0, 0, 0, 0, 0, 0),             mk_out(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)});
        vt.push_back('{"fetch busy",   mk_in(1, 32'h40, 0, 0, 0, 0, 0, 1, I0),            mk_out(1, 0, 32'h40, 0, 3'b010, 0, 0, 1, 0, 0, 0, 0, 0, 0)});
        vt.push_back('{"fetch resp",   mk_in(1, 32'h40, 0, 0, 0, 0, 0, 0, 0),             mk_out(0, 0, 32'h40, 0, 3'b010, 1, I0, 0, 0, 0, 0, 0, 0, 0)});
        vt.push_back('{"fetch done",   mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0),                  mk_out(0, 0, 32'h40, 0, 3'b010, 0, I0, 0, 0, 0, 0, 1, 0, 0)});
        vt.push_back('{"store req",    mk_in(0, 0, 1, 1, 32'h100, DB, 3'b010, 0, 0),      mk_out(0, 0, 32'h40, 0, 3'b010, 0, I0, 0, 0, 0, 1, 1, 0, 0)});
        vt.push_back('{"store busy1",  mk_in(0, 0, 1, 1, 32'h100, DB, 3'b010, 0, 0),      mk_out(1, 1, 32'h100, DB, 3'b010, 0, I0, 0, 0, 0, 1, 1, 0, 0)});
        vt.push_back('{"store busy2",  mk_in(0, 0, 1, 1, 32'h100, DB, 3'b010, 0, 0),      mk_out(1, 1, 32'h100, DB, 3'b010, 0, I0, 0, 0, 0, 1, 1, 0, 0)});
        vt.push_back('{"store ready",  mk_in(0, 0, 1, 1, 32'h100, DB, 3'b010, 1, 32'h12345678), mk_out(1, 1, 32'h100, DB, 3'b010, 0, I0, 0, 0, 0, 1, 1, 0, 0)});
        vt.push_back('{"store resp",   mk_in(0, 0, 1, 1, 32'h100, DB, 3'b010, 1, 32'hAAAA5555), mk_out(0, 1, 32'h100, DB, 3'b010, 0, I0, 0, 1, 0, 0, 1, 0, 0)});
        vt.push_back('{"load req",     mk_in(0, 0, 1, 0, 32'h104, W1, 3'b100, 0, 0),      mk_out(0, 1, 32'h100, DB, 3'b010, 0, I0, 0, 0, 0, 1, 1, 1, 0)});
        vt.push_back('{"load busy",    mk_in(0, 0, 1, 0, 32'h104, W1, 3'b100, 1, LD),     mk_out(1, 0, 32'h104, W1, 3'b100, 0, I0, 0, 0, 0, 1, 1, 1, 0)});
        vt.push_back('{"load resp held", mk_in(0, 0, 1, 0, 32'h104, W1, 3'b100, 0, 0),    mk_out(0, 0, 32'h104, W1, 3'b100, 0, I0, 0, 1, LD, 0, 1, 1, 0)});
        vt.push_back('{"no regrant",   mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0),                  mk_out(0, 0, 32'h104, W1, 3'b100, 0, I0, 0, 0, LD, 0, 1, 2, 0)});

        reset = 1'b1;
        drive('0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        foreach (vt[k]) begin
            step(vt[k].name, vt[k].stim, vt[k].exp);
        end

        // Two back-to-back conflicts after reset: data first, then fetch.
        apply_reset();
        step("conf1 idle",  mk_in(1, 32'h80, 1, 0, 32'h200, 0, 3'b010, 0, 0),  mk_out(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
        step("conf1 busy",  mk_in(1, 32'h80, 1, 0, 32'h200, 0, 3'b010, 0, 0),  mk_out(1, 0, 32'h200, 0, 3'b010, 0, 0, 1, 0, 0, 1, 0, 0, 1));
        step("conf1 ready", mk_in(1, 32'h80, 1, 0, 32'h200, 0, 3'b010, 1, LA), mk_out(1, 0, 32'h200, 0, 3'b010, 0, 0, 1, 0, 0, 1, 0, 0, 2));
        step("conf1 resp",  mk_in(1, 32'h80, 1, 0, 32'h200, 0, 3'b010, 0, 0),  mk_out(0, 0, 32'h200, 0, 3'b010, 0, 0, 1, 1, LA, 0, 0, 0, 3));
        step("conf2 idle",  mk_in(1, 32'h80, 1, 0, 32'h204, 0, 3'b010, 0, 0),  mk_out(0, 0, 32'h200, 0, 3'b010, 0, 0, 1, 0, LA, 1, 0, 1, 3));
        step("conf2 busy",  mk_in(1, 32'h80, 1, 0, 32'h204, 0, 3'b010, 1, I1), mk_out(1, 0, 32'h80, 0, 3'b010, 0, 0, 1, 0, LA, 1, 0, 1, 4));
        step("conf2 resp",  mk_in(1, 32'h80, 1, 0, 32'h204, 0, 3'b010, 0, 0),  mk_out(0, 0, 32'h80, 0, 3'b010, 1, I1, 0, 0, LA, 1, 0, 1, 5));
        step("conf2 after", mk_in(0, 0, 1, 0, 32'h204, 0, 3'b010, 0, 0),       mk_out(0, 0, 32'h80, 0, 3'b010, 0, I1, 0, 0, LA, 1, 1, 1, 5));
        step("data served", mk_in(0, 0, 1, 0, 32'h204, 0, 3'b010, 0, 0),       mk_out(1, 0, 32'h204, 0, 3'b010, 0, I1, 0, 0, LA, 1, 1, 1, 5));

        // Reset in the middle of a load; the late memory response must be dropped.
        apply_reset();
        step("rst load req",  mk_in(0, 0, 1, 0, 32'h300, 0, 3'b010, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        step("rst load busy", mk_in(0, 0, 1, 0, 32'h300, 0, 3'b010, 0, 0), mk_out(1, 0, 32'h300, 0, 3'b010, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        drive('0);
        reset = 1'b1;
        #1;
        check("rst asserted", zero_o);
        @(negedge clk);
        reset = 1'b0;
        step("late ready",  mk_in(0, 0, 0, 0, 0, 0, 0, 1, 32'hBAD0BAD0), zero_o);
        step("after late",  mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0),            zero_o);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter that shares the core's single-ported unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store). It replaces fixed clock-phase address multiplexing with an explicit request/grant/response handshake. It also generates per-requester stall signals that hold the PC, IF/ID and the downstream pipeline while an access is outstanding or waiting.

## Interface

Parameters:
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr stable until if_rvalid
- if_addr  in  AW  fetch address (PC)
- if_rvalid  out  1  one-cycle pulse; fetch complete, if_rdata valid
- if_rdata  out  DW  fetched instruction
- if_stall  out  1  fetch outstanding or waiting
- d_req  in  1  data request; held with all d_* inputs stable until d_rvalid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address (EX/MEM ALU result)
- d_wdata  in  DW  store data
- d_funct3  in  3  access size/sign, passed through unchanged
- d_rvalid  out  1  one-cycle pulse; load or store complete
- d_rdata  out  DW  load data; unchanged on store completion
- d_stall  out  1  data access outstanding or waiting
- mem_req  out  1  memory access active
- mem_we  out  1  write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_funct3  out  3  memory size/sign
- mem_ready  in  1  memory completes the current access this cycle
- mem_rdata  in  DW  memory read data, valid with mem_ready
- perf_fetch, perf_data, perf_conflict  out  32 each  performance counters (see Configuration)

## Operation

- States: IDLE, BUSY_F, BUSY_D, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, only one request: grant it. Latch addr/we/wdata/funct3 into the output registers. Go to BUSY_F or BUSY_D.
- IDLE, both requests: round-robin on the last_grant bit.
  - Data wins unless last_grant = DATA; in that case fetch wins.
  - last_grant resets to FETCH, so the first conflict goes to data.
- BUSY_x:
  - mem_req = 1 and all mem_* outputs are held.
  - On mem_ready: capture mem_rdata into the selected response register (loads only for data), update last_grant, go to RESP.
- RESP:
  - Pulse the matching rvalid for exactly one cycle, then return to IDLE.
  - Arbitration does not take place in RESP. This keeps the completing requester's stale req from being re-granted.
- mem_ready is ignored in IDLE and RESP.
- mem_we = 0 for every fetch.
- if_stall = if_req & ~if_rvalid; d_stall = d_req & ~d_rvalid (combinational).
- Reset, including mid-access: state = IDLE, last_grant = FETCH, mem_req = mem_we = 0, mem_addr/mem_wdata/mem_funct3 = 0, if_rdata/d_rdata = 0, rvalid pulses = 0, perf counters = 0.
  - A memory response that arrives after reset is dropped.

## Timing

- Request sampled in IDLE at cycle 0.
- mem_req high from cycle 1 until the mem_ready cycle k (k ≥ 1).
- rvalid at cycle k+1; earliest completion is cycle 2.
- Minimum service interval is 3 cycles (IDLE, BUSY, RESP).
- A requester may drop or change its request in the cycle after its rvalid.
- A loser of arbitration waits at most one full access of the other requester.

## Configuration

- MEM_PORT_ARB_PERF_EN defined: three saturating 32-bit counters.
  - perf_fetch increments on each if_rvalid.
  - perf_data increments on each d_rvalid.
  - perf_conflict increments every cycle in which a request is asserted but not being served: both requests in IDLE, if_req in BUSY_D, or d_req in BUSY_F.
- Undefined: no counter logic; perf_* tied to 0. Ports are present in both builds.

## Structure

- Shared package mem_arb_pkg: the state enum (IDLE, BUSY_F, BUSY_D, RESP), grant encoding (FETCH = 0, DATA = 1), AW/DW defaults.
- One sub-module, mem_arb_perf_cnt: the three saturating counters. It is instantiated only under MEM_PORT_ARB_PERF_EN.

## Test plan

- Fetch only: if_addr = 0x40, memory ready after 1 cycle with 0x00500093 -> mem_addr = 0x40, mem_we = 0; if_rvalid at cycle 2 with if_rdata = 0x00500093; if_stall high in cycles 0–1.
- Store: d_we = 1, d_addr = 0x100, d_wdata = 0xDEADBEEF, funct3 = 010, memory latency 3 -> mem_req high for cycles 1–3 with stable outputs; d_rvalid at cycle 4; d_rdata unchanged.
- Simultaneous requests twice in a row after reset -> first grant data, second grant fetch; loser's stall stays high throughout; perf_conflict counts the waiting cycles (PERF build).
- Reset asserted in BUSY_D with mem_ready arriving the cycle after reset release -> IDLE, mem_req = 0, no rvalid pulse, d_rdata = 0.
- Requester holds req through RESP -> no re-grant in RESP; a fresh request after rvalid is serviced normally.
- Non-PERF build -> perf_* read 0 throughout all scenarios above.
